vending_machine_multi: RTL and testbench
========================================

// Module: vending_machine_multi
// PURPOSE
//  Next-generation vending controller: NUM_ITEMS products, each with its own price and stock count.
//  Accumulates 1/2/5 coin credit and accepts an item selection.
//  Dispenses the item, then returns change serially, one coin per cycle (greedy 5/2/1).
//  Supports cancel/refund, sold-out detection, credit saturation with coin rejection, and restock.
// PARAMETERS
//  NUM_ITEMS   4                          number of products; select index width = $clog2(NUM_ITEMS)
//  CREDIT_W    5                          width of the credit, price and remaining-change datapath
//  MAX_CREDIT  20                         credit ceiling; a coin that would exceed it is rejected
//  PRICES      {5'd12,5'd9,5'd7,5'd3}     packed NUM_ITEMS*CREDIT_W; item0=3, item1=7, item2=9, item3=12
//  STOCK_W     4                          per-item stock counter width
//  INIT_STOCK  4                          stock loaded into every item at reset
//  STOCK_MAX   15                         stock loaded into an item by restock
// PORTS
//  clk            in   1           single clock, rising edge
//  reset          in   1           synchronous, active-high
//  coin           in   3           3'b001=1, 3'b010=2, 3'b101=5, 3'b000=none; any other code is invalid
//  sel_valid      in   1           selection strobe
//  sel_item       in   IDX_W       selected item index
//  cancel         in   1           refund request
//  restock_valid  in   1           restock strobe
//  restock_item   in   IDX_W       item to restock
//  dispense       out  1           1-cycle pulse, item released
//  item_out       out  IDX_W       item index, valid while dispense=1
//  coin_out_valid out  1           a change coin is emitted this cycle
//  coin_out       out  3           change coin code (same encoding as coin)
//  coin_reject    out  1           1-cycle pulse: the coin presented last cycle is returned
//  sel_error      out  1           1-cycle pulse: selection refused (sold out or insufficient credit)
//  item_empty     out  NUM_ITEMS   level: bit i=1 when stock[i]==0
//  credit         out  CREDIT_W    current accumulated credit
//  busy           out  1           high in VEND and CHANGE
// BEHAVIOUR
//  Timing: all outputs are registered; every pulse appears in the cycle after the causing input.
//  Reset (synchronous): state=COLLECT, credit=0, remaining=0, every stock=INIT_STOCK.
//   All pulse outputs are 0, item_out=0, coin_out=0.
//   Reset asserted mid-VEND or mid-CHANGE aborts immediately; coins still owed are dropped.
//  FSM states: COLLECT, VEND, CHANGE.
//  COLLECT priority each cycle: cancel > sel_valid > coin.
//   cancel: if credit>0, latch remaining=credit, clear credit, go to CHANGE.
//    If credit==0, cancel has no effect.
//   sel_valid with stock[sel]==0 or credit<PRICES[sel]: sel_error pulse; credit unchanged.
//   sel_valid accepted: latch item, remaining=credit-PRICES[sel], clear credit, go to VEND.
//   Any coin presented in the same cycle as an accepted cancel or select is rejected (coin_reject).
//   Valid coin with credit+value<=MAX_CREDIT: credit+=value.
//    Otherwise coin_reject pulse; credit unchanged.
//   Invalid nonzero coin code: coin_reject pulse.
//  VEND (exactly 1 cycle): dispense=1, item_out=latched item, stock[item] decremented.
//   Next state: CHANGE if remaining>0, else COLLECT.
//  CHANGE, each cycle: coin_out_valid=1 with the largest denomination <= remaining (5, then 2, then 1).
//   remaining is reduced by that value.
//   Returns to COLLECT in the cycle the last coin is emitted; coin count = greedy count of remaining.
//  During VEND and CHANGE: any nonzero coin -> coin_reject; sel_valid and cancel are ignored (no sel_error).
//  Latency: select in cycle N -> dispense in N+1 -> first change coin in N+2.
//   cancel in N -> first coin in N+1.
//  Restock: accepted in any state; sets stock[restock_item]=STOCK_MAX.
//   Restock wins over a same-cycle decrement of the same item.
//  Width rules: compare credit+value at CREDIT_W+1 bits. Stock never decrements below 0 (guarded by the sold-out check).
// STRUCTURE
//  Package vm_pkg: coin code constants (COIN_NONE/1/2/5), a coin-value function, and the state encoding.
//  Sub-module vm_change_dispenser: loads remaining, emits one greedy coin per cycle, and signals done.
//  Top level holds the FSM, credit accumulator, stock array and PRICES slicing.
// TESTING
//  1. Coins 5,2, select item1 (price 7) -> dispense=1 with item_out=1 one cycle later; no coin_out; credit=0; stock[1]=3.
//  2. Coins 5,5, select item0 (price 3) -> dispense, then coin_out 5, then 2 on consecutive cycles; then back to COLLECT.
//  3. Coins 5,2,1, then cancel -> coin_out 5,2,1; dispense never asserted; credit=0.
//  4. Coins 5,5,5,5 (credit 20), then coin 1 -> coin_reject; credit stays 20.
//     Then select item0 -> change 5,5,5,2 (remaining 17).
//  5. Buy item2 four times -> item_empty[2]=1; fifth select with credit 9 -> sel_error; credit stays 9.
//     Restock item2 -> item_empty[2]=0 and stock=15; the retried select succeeds.
//  6. Select+coin in the same cycle -> coin_reject. Coin during CHANGE -> coin_reject.
//     Reset mid-CHANGE -> coin_out_valid=0 next cycle; all stock back to 4.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the multi-item vending controller.
//  - Coin codes, shared by the coin input and the change output.
//  - Coin decode helpers.
//  - FSM state encoding.
package vm_pkg;

   localparam logic [2:0] COIN_NONE = 3'b000;
   localparam logic [2:0] COIN_1    = 3'b001;
   localparam logic [2:0] COIN_2    = 3'b010;
   localparam logic [2:0] COIN_5    = 3'b101;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_VEND    = 2'd1,
      ST_CHANGE  = 2'd2
   } vm_state_t;

   // True only for the three legal denominations (COIN_NONE is not a coin)
   function automatic logic coin_is_valid(input logic [2:0] code);
      case (code)
         COIN_1, COIN_2, COIN_5: coin_is_valid = 1'b1;
         default:                coin_is_valid = 1'b0;
      endcase
   endfunction

   // Monetary value of a coin code; illegal codes are worth nothing
   function automatic logic [2:0] coin_value(input logic [2:0] code);
      case (code)
         COIN_1:  coin_value = 3'd1;
         COIN_2:  coin_value = 3'd2;
         COIN_5:  coin_value = 3'd5;
         default: coin_value = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Serial change dispenser.
//  load/load_value : capture an amount owed; the first coin is emitted the next cycle
//  coin_out_valid  : registered, one greedy (5/2/1) coin per cycle while money is owed
//  coin_out        : registered coin code
//  done            : nothing further is owed after the coin currently shown
module vm_change_dispenser
   import vm_pkg::*;
#(
   parameter int CREDIT_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [CREDIT_W-1:0] load_value,
   output logic                coin_out_valid,
   output logic [2:0]          coin_out,
   output logic                done
);

   logic [CREDIT_W-1:0] remaining_r;
   logic                coin_valid_r;
   logic [2:0]          coin_r;
   logic [CREDIT_W-1:0] src_s;
   logic [2:0]          coin_s;
   logic [CREDIT_W-1:0] next_rem_s;

   // Largest denomination not exceeding the amount still owed
   function automatic logic [2:0] greedy_coin(input logic [CREDIT_W-1:0] amount);
      if (amount >= CREDIT_W'(5)) begin
         greedy_coin = COIN_5;
      end else if (amount >= CREDIT_W'(2)) begin
         greedy_coin = COIN_2;
      end else if (amount != {CREDIT_W{1'b0}}) begin
         greedy_coin = COIN_1;
      end else begin
         greedy_coin = COIN_NONE;
      end
   endfunction

   // A load supersedes whatever is left; pick the next coin from the active amount
   always_comb begin
      src_s      = load ? load_value : remaining_r;
      coin_s     = greedy_coin(src_s);
      next_rem_s = src_s - CREDIT_W'(coin_value(coin_s));
   end

   // Emit one coin per cycle and track what is still owed
   always_ff @(posedge clk) begin
      if (reset) begin
         remaining_r  <= {CREDIT_W{1'b0}};
         coin_valid_r <= 1'b0;
         coin_r       <= COIN_NONE;
      end else if (load || (remaining_r != {CREDIT_W{1'b0}})) begin
         remaining_r  <= next_rem_s;
         coin_valid_r <= (coin_s != COIN_NONE);
         coin_r       <= coin_s;
      end else begin
         remaining_r  <= {CREDIT_W{1'b0}};
         coin_valid_r <= 1'b0;
         coin_r       <= COIN_NONE;
      end
   end

   assign coin_out_valid = coin_valid_r;
   assign coin_out       = coin_r;
   assign done           = (remaining_r == {CREDIT_W{1'b0}});

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller with per-item price and stock.
//  clk, reset            : clock, synchronous active-high reset
//  coin                  : inserted coin code (1/2/5, 0 = none)
//  sel_valid/sel_item    : item selection strobe and index
//  cancel                : refund the accumulated credit
//  restock_valid/_item   : refill one item to STOCK_MAX
//  dispense/item_out     : one-cycle item release pulse and index
//  coin_out_valid/_out   : serial change, one coin per cycle
//  coin_reject           : coin presented last cycle is returned
//  sel_error             : selection refused (sold out / short credit)
//  item_empty            : per-item sold-out flags
//  credit                : accumulated credit
//  busy                  : vending or returning change
module vending_machine_multi
   import vm_pkg::*;
#(
   parameter int NUM_ITEMS  = 4,
   parameter int CREDIT_W   = 5,
   parameter int MAX_CREDIT = 20,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {5'd12, 5'd9, 5'd7, 5'd3},
   parameter int STOCK_W    = 4,
   parameter int INIT_STOCK = 4,
   parameter int STOCK_MAX  = 15,
   localparam int IDX_W     = $clog2(NUM_ITEMS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           coin,
   input  logic                 sel_valid,
   input  logic [IDX_W-1:0]     sel_item,
   input  logic                 cancel,
   input  logic                 restock_valid,
   input  logic [IDX_W-1:0]     restock_item,
   output logic                 dispense,
   output logic [IDX_W-1:0]     item_out,
   output logic                 coin_out_valid,
   output logic [2:0]           coin_out,
   output logic                 coin_reject,
   output logic                 sel_error,
   output logic [NUM_ITEMS-1:0] item_empty,
   output logic [CREDIT_W-1:0]  credit,
   output logic                 busy
);

   vm_state_t                            state_r;
   logic [CREDIT_W-1:0]                  credit_r;
   logic [CREDIT_W-1:0]                  remaining_r;
   logic [IDX_W-1:0]                     item_r;
   logic [NUM_ITEMS-1:0][STOCK_W-1:0]    stock_r;
   logic [NUM_ITEMS-1:0][STOCK_W-1:0]    stock_nxt_s;
   logic [NUM_ITEMS-1:0]                 empty_nxt_s;
   logic [NUM_ITEMS-1:0]                 item_empty_r;
   logic                                 dispense_r;
   logic [IDX_W-1:0]                     item_out_r;
   logic                                 coin_reject_r;
   logic                                 sel_error_r;
   logic                                 busy_r;

   logic [CREDIT_W-1:0]                  price_s;
   logic                                 sel_ok_s;
   logic [CREDIT_W:0]                    coin_sum_s;
   logic                                 coin_fits_s;
   logic                                 coin_present_s;
   logic                                 dsp_load_s;
   logic [CREDIT_W-1:0]                  dsp_value_s;
   logic                                 dsp_done_s;

   // Selection and coin acceptance qualifiers; the sum is one bit wider so it cannot wrap
   always_comb begin
      price_s        = PRICES[int'(sel_item)*CREDIT_W +: CREDIT_W];
      sel_ok_s       = (stock_r[sel_item] != {STOCK_W{1'b0}}) && (credit_r >= price_s);
      coin_sum_s     = {1'b0, credit_r} + (CREDIT_W+1)'(coin_value(coin));
      coin_fits_s    = coin_is_valid(coin) && (coin_sum_s <= (CREDIT_W+1)'(MAX_CREDIT));
      coin_present_s = (coin != COIN_NONE);
   end

   // Hand the change dispenser its amount: a refund straight from COLLECT, or post-vend change
   always_comb begin
      if ((state_r == ST_COLLECT) && cancel && (credit_r != {CREDIT_W{1'b0}})) begin
         dsp_load_s  = 1'b1;
         dsp_value_s = credit_r;
      end else if ((state_r == ST_VEND) && (remaining_r != {CREDIT_W{1'b0}})) begin
         dsp_load_s  = 1'b1;
         dsp_value_s = remaining_r;
      end else begin
         dsp_load_s  = 1'b0;
         dsp_value_s = {CREDIT_W{1'b0}};
      end
   end

   // Next stock: vend decrement first, then restock so a same-item restock wins
   always_comb begin
      stock_nxt_s = stock_r;
      if ((state_r == ST_VEND) && (stock_r[item_r] != {STOCK_W{1'b0}})) begin
         stock_nxt_s[item_r] = stock_r[item_r] - STOCK_W'(1);
      end else begin
         stock_nxt_s[item_r] = stock_r[item_r];
      end
      if (restock_valid) begin
         stock_nxt_s[restock_item] = STOCK_W'(STOCK_MAX);
      end else begin
         stock_nxt_s[restock_item] = stock_nxt_s[restock_item];
      end
      for (int i = 0; i < NUM_ITEMS; i++) begin
         empty_nxt_s[i] = (stock_nxt_s[i] == {STOCK_W{1'b0}});
      end
   end

   // Stock array and the registered sold-out flags
   always_ff @(posedge clk) begin
      if (reset) begin
         stock_r      <= {NUM_ITEMS{STOCK_W'(INIT_STOCK)}};
         item_empty_r <= {NUM_ITEMS{(INIT_STOCK == 0)}};
      end else begin
         stock_r      <= stock_nxt_s;
         item_empty_r <= empty_nxt_s;
      end
   end

   // Main FSM: credit accumulation, selection, vend pulse and change hand-off
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_COLLECT;
         credit_r      <= {CREDIT_W{1'b0}};
         remaining_r   <= {CREDIT_W{1'b0}};
         item_r        <= {IDX_W{1'b0}};
         dispense_r    <= 1'b0;
         item_out_r    <= {IDX_W{1'b0}};
         coin_reject_r <= 1'b0;
         sel_error_r   <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         dispense_r    <= 1'b0;
         item_out_r    <= {IDX_W{1'b0}};
         coin_reject_r <= 1'b0;
         sel_error_r   <= 1'b0;
         case (state_r)
            ST_COLLECT: begin
               if (cancel && (credit_r != {CREDIT_W{1'b0}})) begin
                  credit_r      <= {CREDIT_W{1'b0}};
                  state_r       <= ST_CHANGE;
                  busy_r        <= 1'b1;
                  coin_reject_r <= coin_present_s;
               end else if (sel_valid && sel_ok_s) begin
                  item_r        <= sel_item;
                  remaining_r   <= credit_r - price_s;
                  credit_r      <= {CREDIT_W{1'b0}};
                  state_r       <= ST_VEND;
                  busy_r        <= 1'b1;
                  dispense_r    <= 1'b1;
                  item_out_r    <= sel_item;
                  coin_reject_r <= coin_present_s;
               end else begin
                  // A refused selection still lets a same-cycle coin be credited
                  sel_error_r <= sel_valid;
                  busy_r      <= 1'b0;
                  if (coin_fits_s) begin
                     credit_r <= coin_sum_s[CREDIT_W-1:0];
                  end else begin
                     coin_reject_r <= coin_present_s;
                  end
               end
            end
            ST_VEND: begin
               coin_reject_r <= coin_present_s;
               remaining_r   <= {CREDIT_W{1'b0}};
               if (remaining_r != {CREDIT_W{1'b0}}) begin
                  state_r <= ST_CHANGE;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_COLLECT;
                  busy_r  <= 1'b0;
               end
            end
            ST_CHANGE: begin
               coin_reject_r <= coin_present_s;
               if (dsp_done_s) begin
                  state_r <= ST_COLLECT;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_CHANGE;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_COLLECT;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   vm_change_dispenser #(
      .CREDIT_W (CREDIT_W)
   ) u_change (
      .clk            (clk),
      .reset          (reset),
      .load           (dsp_load_s),
      .load_value     (dsp_value_s),
      .coin_out_valid (coin_out_valid),
      .coin_out       (coin_out),
      .done           (dsp_done_s)
   );

   assign dispense    = dispense_r;
   assign item_out    = item_out_r;
   assign coin_reject = coin_reject_r;
   assign sel_error   = sel_error_r;
   assign item_empty  = item_empty_r;
   assign credit      = credit_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: a transaction-level model
// (credit, stock counts and a queue of upcoming output slots) is checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_vending_machine_multi;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] coin;
   logic       sel_valid;
   logic [1:0] sel_item;
   logic       cancel;
   logic       restock_valid;
   logic [1:0] restock_item;
   logic       dispense;
   logic [1:0] item_out;
   logic       coin_out_valid;
   logic [2:0] coin_out;
   logic       coin_reject;
   logic       sel_error;
   logic [3:0] item_empty;
   logic [4:0] credit;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;

   // Model state. Each queue entry is one future output cycle:
   // 1/2/5 = change coin of that value, 100+i = dispense item i.
   int m_credit;
   int m_stock [4];
   int m_q [$];
   int m_cur;
   int m_rej;
   int m_serr;
   int prices [4] = '{3, 7, 9, 12};

   always #5 clk = ~clk;

   vending_machine_multi dut (
      .clk            (clk),
      .reset          (reset),
      .coin           (coin),
      .sel_valid      (sel_valid),
      .sel_item       (sel_item),
      .cancel         (cancel),
      .restock_valid  (restock_valid),
      .restock_item   (restock_item),
      .dispense       (dispense),
      .item_out       (item_out),
      .coin_out_valid (coin_out_valid),
      .coin_out       (coin_out),
      .coin_reject    (coin_reject),
      .sel_error      (sel_error),
      .item_empty     (item_empty),
      .credit         (credit),
      .busy           (busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int coin_val(input logic [2:0] c);
      case (c)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b101:  return 5;
         default: return 0;
      endcase
   endfunction

   // Change for an amount, greedy, by plain division
   task automatic push_change(input int amt);
      for (int k = 0; k < amt / 5; k++) m_q.push_back(5);
      for (int k = 0; k < (amt % 5) / 2; k++) m_q.push_back(2);
      for (int k = 0; k < (amt % 5) % 2; k++) m_q.push_back(1);
   endtask

   // Advance the model across one rising edge using the inputs held this cycle
   task automatic model_edge();
      int v;
      m_rej  = 0;
      m_serr = 0;
      if (reset) begin
         m_credit = 0;
         for (int i = 0; i < 4; i++) m_stock[i] = 4;
         m_q.delete();
         m_cur = -1;
      end else begin
         if (m_cur >= 100 && m_stock[m_cur-100] > 0) m_stock[m_cur-100]--;
         if (m_cur == -1) begin
            v = coin_val(coin);
            if (cancel && m_credit > 0) begin
               push_change(m_credit);
               m_credit = 0;
               m_rej = (coin != 3'b000);
            end else if (sel_valid && m_stock[sel_item] > 0 && m_credit >= prices[sel_item]) begin
               m_q.push_back(100 + int'(sel_item));
               push_change(m_credit - prices[sel_item]);
               m_credit = 0;
               m_rej = (coin != 3'b000);
            end else begin
               m_serr = sel_valid;
               if (coin != 3'b000) begin
                  if (v != 0 && m_credit + v <= 20) m_credit += v;
                  else m_rej = 1;
               end
            end
         end else begin
            m_rej = (coin != 3'b000);
         end
         if (restock_valid) m_stock[restock_item] = 15;
         m_cur = (m_q.size() > 0) ? m_q.pop_front() : -1;
      end
   endtask

   // One clock: edge, model update, compare all outputs, clear strobes
   task automatic tick();
      int emp;
      @(posedge clk);
      model_edge();
      #1;
      emp = 0;
      for (int i = 0; i < 4; i++) if (m_stock[i] == 0) emp |= (1 << i);
      chk("dispense", dispense, (m_cur >= 100));
      if (m_cur >= 100) chk("item_out", item_out, m_cur - 100);
      chk("coin_out_valid", coin_out_valid, (m_cur >= 1 && m_cur <= 5));
      if (m_cur >= 1 && m_cur <= 5) chk("coin_out", coin_out, m_cur);
      chk("coin_reject", coin_reject, m_rej);
      chk("sel_error", sel_error, m_serr);
      chk("credit", credit, m_credit);
      chk("busy", busy, (m_cur != -1));
      chk("item_empty", item_empty, emp);
      reset = 1'b0; coin = 3'b000; sel_valid = 1'b0; cancel = 1'b0; restock_valid = 1'b0;
   endtask

   task automatic put(input logic [2:0] c);
      coin = c;
      tick();
   endtask

   task automatic buy(input logic [1:0] i);
      sel_valid = 1'b1;
      sel_item  = i;
      tick();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   int exp4 [4] = '{5, 5, 5, 2};

   initial begin
      reset = 1'b1; coin = 3'b000; sel_valid = 1'b0; sel_item = 2'd0;
      cancel = 1'b0; restock_valid = 1'b0; restock_item = 2'd0;
      m_cur = -1; m_credit = 0;
      tick();
      reset = 1'b1;
      tick();
      chk("reset_credit", credit, 0);
      chk("reset_empty", item_empty, 0);

      // 1: exact price, no change
      put(3'b101); put(3'b010);
      buy(2'd1);
      chk("t1_dispense", dispense, 1);
      chk("t1_item", item_out, 1);
      idle(1);
      chk("t1_nochange", coin_out_valid, 0);
      chk("t1_credit", credit, 0);

      // 2: change 7 -> 5,2
      put(3'b101); put(3'b101);
      buy(2'd0);
      idle(1);
      chk("t2_c0", coin_out, 5);
      idle(1);
      chk("t2_c1", coin_out, 2);
      idle(1);
      chk("t2_idle", busy, 0);

      // 3: cancel refund 8 -> 5,2,1
      put(3'b101); put(3'b010); put(3'b001);
      cancel = 1'b1;
      tick();
      chk("t3_c0", coin_out, 5);
      idle(1);
      chk("t3_c1", coin_out, 2);
      idle(1);
      chk("t3_c2", coin_out, 1);
      idle(1);
      chk("t3_done", coin_out_valid, 0);

      // 4: saturation at 20, then change 17 -> 5,5,5,2
      put(3'b101); put(3'b101); put(3'b101); put(3'b101);
      put(3'b001);
      chk("t4_reject", coin_reject, 1);
      chk("t4_credit", credit, 20);
      put(3'b011);
      chk("t4_invalid", coin_reject, 1);
      buy(2'd0);
      for (int k = 0; k < 4; k++) begin
         idle(1);
         chk("t4_change", coin_out, exp4[k]);
      end
      idle(1);

      // 5: sell out item2, refusal, restock, retry
      for (int k = 0; k < 4; k++) begin
         put(3'b101); put(3'b010); put(3'b010);
         buy(2'd2);
         idle(1);
      end
      chk("t5_empty", item_empty, 4'b0100);
      put(3'b101); put(3'b010); put(3'b010);
      buy(2'd2);
      chk("t5_selerr", sel_error, 1);
      chk("t5_credit", credit, 9);
      restock_valid = 1'b1; restock_item = 2'd2;
      tick();
      chk("t5_restock", item_empty, 4'b0000);
      buy(2'd2);
      chk("t5_retry", dispense, 1);
      idle(2);

      // 6: coin with select, coin during change, reset mid-change
      put(3'b101);
      coin = 3'b010;
      buy(2'd0);
      chk("t6_selcoin", coin_reject, 1);
      idle(2);
      put(3'b101); put(3'b101); put(3'b101);
      buy(2'd0);
      idle(1);
      put(3'b001);
      chk("t6_changecoin", coin_reject, 1);
      idle(3);
      put(3'b101); put(3'b101); put(3'b101);
      cancel = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      chk("t6_abort", coin_out_valid, 0);
      chk("t6_stock", item_empty, 4'b0000);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
